// File: rtl/aardvark_pkg.sv
// Shared definitions for the 8-bit computer front end: widths, opcode values and
// fetch/decode state encoding.
package aardvark_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 8;
  localparam int OPC_W   = 3;
  localparam int IMM_W   = 5;

  localparam logic [OPC_W-1:0]   OPC_HALT  = 3'b111;
  localparam logic [INSTR_W-1:0] HALT_WORD = {OPC_HALT, {IMM_W{1'b0}}};

  typedef enum logic [1:0] {
    IFD_IDLE   = 2'd0,
    IFD_FETCH  = 2'd1,
    IFD_HOLD   = 2'd2,
    IFD_HALTED = 2'd3
  } ifd_state_e;

  function automatic logic [OPC_W-1:0] instr_opcode(input logic [INSTR_W-1:0] w);
    return w[INSTR_W-1 -: OPC_W];
  endfunction

  function automatic logic [IMM_W-1:0] instr_imm5(input logic [INSTR_W-1:0] w);
    return w[IMM_W-1:0];
  endfunction

endpackage

// File: rtl/instr_fetch_decode_if.sv
// Instruction-memory fetch port and decode output port of the fetch/decode stage.
// master = fetch/decode stage, slave = memory plus downstream consumer.
interface instr_fetch_decode_if;
  import aardvark_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  logic               dec_valid;
  logic               dec_ready;
  logic [OPC_W-1:0]   dec_opcode;
  logic [IMM_W-1:0]   dec_imm5;
  logic [PC_W-1:0]    dec_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output dec_valid, dec_opcode, dec_imm5, dec_pc,
    input  dec_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  dec_valid, dec_opcode, dec_imm5, dec_pc,
    output dec_ready
  );

endinterface

// File: rtl/instr_fetch_decode_fetch_pc.sv
// Program counter register: load has priority over increment; increment wraps
// modulo 2^PC_W.
module fetch_pc
  import aardvark_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_en,
  input  logic [PC_W-1:0] load_addr,
  input  logic            inc_en,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_en)     pc_d = load_addr;
    else if (inc_en) pc_d = pc_q + PC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode stage: fetches 8-bit words over req/ack and presents opcode/imm5 on
// a valid/ready port. Optional retired-instruction counter under INSTR_COUNT_EN.
module instr_fetch_decode
  import aardvark_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  instr_fetch_decode_if.master   bus,
  input  logic                   pc_load,
  input  logic [PC_W-1:0]        pc_load_addr,
`ifdef INSTR_COUNT_EN
  output logic [15:0]            retired_cnt,
`endif
  output logic                   halted
);

  ifd_state_e         state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [PC_W-1:0]    dec_pc_q, dec_pc_d;
  logic [PC_W-1:0]    pc;
  logic               pc_inc;
  logic               accept;

  fetch_pc u_fetch_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (pc_load),
    .load_addr (pc_load_addr),
    .inc_en    (pc_inc),
    .pc        (pc)
  );

  assign accept = (state_q == IFD_HOLD) && bus.dec_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IFD_IDLE;
      ir_q     <= '0;
      dec_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      dec_pc_q <= dec_pc_d;
    end
  end

  // A redirect overrides everything, including a same-cycle ack or handshake.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    dec_pc_d = dec_pc_q;
    pc_inc   = 1'b0;
    if (pc_load) begin
      state_d = IFD_FETCH;
    end else begin
      case (state_q)
        IFD_IDLE: state_d = IFD_FETCH;
        IFD_FETCH: begin
          if (bus.imem_ack) begin
            ir_d     = bus.imem_rdata;
            dec_pc_d = pc;
            pc_inc   = 1'b1;
            state_d  = IFD_HOLD;
          end
        end
        IFD_HOLD: begin
          if (accept) state_d = (ir_q == HALT_WORD) ? IFD_HALTED : IFD_FETCH;
        end
        IFD_HALTED: state_d = IFD_HALTED;
        default:    state_d = IFD_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.imem_req   = (state_q == IFD_FETCH);
    bus.imem_addr  = pc;
    bus.dec_valid  = (state_q == IFD_HOLD);
    bus.dec_opcode = instr_opcode(ir_q);
    bus.dec_imm5   = instr_imm5(ir_q);
    bus.dec_pc     = dec_pc_q;
    halted         = (state_q == IFD_HALTED);
  end

`ifdef INSTR_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign retired_cnt = cnt_q;
`endif

endmodule
